// File: rtl/delayq_arbiter_if.sv
// delayq_arbiter_if: producer lanes, queue strobes and the output
// valid/ready pair in one bundle.
// master: the arbiter. slave: producers, queue and sink.
interface delayq_arbiter_if #(
    parameter int NREQ = 4
) ();
    // producer side
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ack;

    // queue side
    logic              q_we;
    logic [7:0]        q_idata;
    logic              q_oready;
    logic              q_re;
    logic [7:0]        q_wdata;

    // sink side
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;

    modport master (
        input  req, req_data, req_last, q_oready, q_wdata, out_ready,
        output req_ack, q_we, q_idata, q_re, out_valid, out_data
    );

    modport slave (
        output req, req_data, req_last, q_oready, q_wdata, out_ready,
        input  req_ack, q_we, q_idata, q_re, out_valid, out_data
    );
endinterface

// File: rtl/delayq_arbiter.sv
// delayq_arbiter: shares one byte-wide delay queue between NREQ producers.
// The write side grants one producer at a time, round-robin and locked for
// the whole packet (or until MAX_BURST bytes). The read side tracks which
// queued bytes have settled for SETTLE cycles, pops them and holds each one
// in a valid/ready output register.
// Optional: define DELAYQ_ARB_STATS_EN to add the stat_clr input and the
// stat_bytes / stat_stall counters.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; pick first requester from rr pointer, no grant yet
//   BURST | owner locked; one byte per cycle when queue has room
module delayq_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int SETTLE    = 9,   // must be >= 2
    parameter int DEPTH     = 10
) (
    input  logic             clk,
    input  logic             rst,
    delayq_arbiter_if.master bus
`ifdef DELAYQ_ARB_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_bytes,
    output logic [15:0]      stat_stall
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OCCW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [7:0]        burst_q, burst_d;
    logic [OCCW-1:0]   occ_q, occ_d;
    logic [OCCW-1:0]   ripe_q, ripe_d;
    logic [SETTLE-1:0] settle_q, settle_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;

    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic              owner_req;
    logic              owner_last;
    logic [7:0]        owner_data;
    logic              room;
    logic              accept;
    logic              settle_exit;
    logic              pop;
    logic [IDXW-1:0]   owner_next;

    // Round-robin scan: lowest offset from rr pointer with req set wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[IDXW'((int'(rr_q) + k) % NREQ)]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    // Owner lane select: request, last flag and data byte.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDXW'(i)) begin
                owner_req  = bus.req[i];
                owner_last = bus.req_last[i];
                owner_data = bus.req_data[8*i +: 8];
            end
        end
    end

    assign room       = (occ_q < OCCW'(DEPTH));
    assign owner_next = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);

    // Arbitration FSM: next state, owner, rr pointer, burst count, accept.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    burst_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // a dropped req without last simply waits here, grant held
                accept = owner_req & bus.q_oready & room;
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                    if (owner_last || (burst_q + 8'd1 == 8'(MAX_BURST))) begin
                        state_d = IDLE;
                        rr_d    = owner_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-side strobes toward producers and queue.
    always_comb begin
        bus.req_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ack[i] = accept & (owner_q == IDXW'(i));
        end
        bus.q_we    = accept;
        bus.q_idata = accept ? owner_data : 8'h00;
    end

    // Read side: the pulse leaving the settle pipe is usable in the same
    // cycle so a byte written at t is popped at exactly t+SETTLE.
    always_comb begin
        settle_exit = settle_q[SETTLE-1];
        pop         = ((ripe_q != '0) | settle_exit) & (~out_valid_q | bus.out_ready);
        settle_d    = {settle_q[SETTLE-2:0], accept};

        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCCW'(1);
            2'b01:   occ_d = occ_q - OCCW'(1);
            default: occ_d = occ_q;
        endcase

        ripe_d = ripe_q;
        case ({settle_exit, pop})
            2'b10:   ripe_d = ripe_q + OCCW'(1);
            2'b01:   ripe_d = ripe_q - OCCW'(1);
            default: ripe_d = ripe_q;
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.q_wdata;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.q_re      = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Arbitration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    // Queue bookkeeping: occupancy, settle pipe and ripe count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= '0;
            ripe_q   <= '0;
            settle_q <= '0;
        end else begin
            occ_q    <= occ_d;
            ripe_q   <= ripe_d;
            settle_q <= settle_d;
        end
    end

    // Output register toward the sink.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef DELAYQ_ARB_STATS_EN
    logic [15:0] stat_bytes_q, stat_bytes_d;
    logic [15:0] stat_stall_q, stat_stall_d;
    logic        stall;

    // Counter next values; clear wins over increment, stall saturates.
    always_comb begin
        stall        = (state_q == BURST) & owner_req & ~accept;
        stat_bytes_d = stat_bytes_q;
        stat_stall_d = stat_stall_q;
        if (stat_clr) begin
            stat_bytes_d = '0;
            stat_stall_d = '0;
        end else begin
            if (pop) begin
                stat_bytes_d = stat_bytes_q + 16'd1;
            end
            if (stall && (stat_stall_q != 16'hFFFF)) begin
                stat_stall_d = stat_stall_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bytes_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_bytes_q <= stat_bytes_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_bytes = stat_bytes_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_delayq_arbiter.sv
// tb_delayq_arbiter: directed and randomized scenarios for delayq_arbiter,
// with a behavioural model (owner / rr pointer / timestamped FIFO) and a
// simple show-ahead queue standing in for the real delay queue.
module tb_delayq_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 16;
    localparam int SETTLE    = 9;
    localparam int DEPTH     = 10;
    localparam int PMAX      = 64;

    logic clk;
    logic rst;

    delayq_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef DELAYQ_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_bytes;
    logic [15:0] stat_stall;
`endif

    delayq_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST), .SETTLE(SETTLE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DELAYQ_ARB_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_bytes(stat_bytes),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // show-ahead queue: q_wdata is the current head, advanced by q_re
    logic [7:0] tq_mem [DEPTH];
    int         tq_rd, tq_wr;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tq_rd <= 0;
            tq_wr <= 0;
        end else begin
            if (bus.q_we) begin
                tq_mem[tq_wr] <= bus.q_idata;
                tq_wr         <= (tq_wr + 1) % DEPTH;
            end
            if (bus.q_re) tq_rd <= (tq_rd + 1) % DEPTH;
        end
    end
    assign bus.q_wdata = tq_mem[tq_rd];

    int errors = 0;
    int checks = 0;

    // producers
    logic [7:0] pdata [NREQ][PMAX];
    bit         plast [NREQ][PMAX];
    int         phead [NREQ];
    int         plen  [NREQ];
    int         gap_pct, qstall_pct, or_pct;

    // reference model
    int         m_owner, m_rr, m_burst, m_cycle;
    logic [7:0] m_data_q [$];
    int         m_time_q [$];
    logic       m_ov;
    logic [7:0] m_od;
    logic [NREQ-1:0] e_ack;
    logic       e_we, e_re;
    logic [7:0] e_idata;

    function automatic void model_reset();
        m_owner = -1; m_rr = 0; m_burst = 0; m_cycle = 0;
        m_data_q.delete(); m_time_q.delete();
        m_ov = 1'b0; m_od = 8'h00;
        e_ack = '0; e_we = 1'b0; e_re = 1'b0; e_idata = 8'h00;
    endfunction

    function automatic void model_eval();
        e_ack = '0; e_we = 1'b0; e_re = 1'b0; e_idata = 8'h00;
        if (m_owner >= 0 && bus.req[m_owner] && bus.q_oready && m_data_q.size() < DEPTH) begin
            e_ack[m_owner] = 1'b1;
            e_we           = 1'b1;
            e_idata        = bus.req_data[8*m_owner +: 8];
        end
        if (m_time_q.size() > 0 && m_cycle >= m_time_q[0] + SETTLE && (!m_ov || bus.out_ready))
            e_re = 1'b1;
    endfunction

    function automatic void model_commit();
        if (e_re) begin
            m_od = m_data_q.pop_front();
            void'(m_time_q.pop_front());
            m_ov = 1'b1;
        end else if (m_ov && bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (e_we) begin
            m_data_q.push_back(e_idata);
            m_time_q.push_back(m_cycle);
        end
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && bus.req[(m_rr + k) % NREQ]) begin
                    m_owner = (m_rr + k) % NREQ;
                    m_burst = 0;
                end
            end
        end else if (e_we) begin
            m_burst++;
            if (bus.req_last[m_owner] || m_burst == MAX_BURST) begin
                m_rr    = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        for (int i = 0; i < NREQ; i++) if (e_ack[i]) phead[i]++;
        m_cycle++;
    endfunction

    function automatic logic [NREQ+18:0] obs_vec();
        return {bus.req_ack, bus.q_we, (bus.q_we ? bus.q_idata : 8'h00),
                bus.q_re, bus.out_valid, bus.out_data};
    endfunction

    function automatic logic [NREQ+18:0] exp_vec();
        return {e_ack, e_we, e_idata, e_re, m_ov, m_od};
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (phead[i] < plen[i] && $urandom_range(99) >= gap_pct) begin
                bus.req[i]           = 1'b1;
                bus.req_data[8*i +: 8] = pdata[i][phead[i]];
                bus.req_last[i]      = plast[i][phead[i]];
            end else begin
                bus.req[i]           = 1'b0;
                bus.req_data[8*i +: 8] = 8'($urandom);
                bus.req_last[i]      = 1'($urandom);
            end
        end
        bus.q_oready  = ($urandom_range(99) >= qstall_pct);
        bus.out_ready = ($urandom_range(99) < or_pct);
    endtask

    task automatic half();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        model_commit();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_prod();
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            plen[i]  = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_prod();
        model_reset();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 1; phead[i] = 0; pdata[i][0] = 8'h5a; plast[i][0] = 1'b1;
        end
        drive();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.req_ack, bus.q_we, bus.q_re, bus.out_valid, bus.out_data} !== '0) begin
                errors++;
                $display("FAIL reset.outputs got=%h exp=0",
                         {bus.req_ack, bus.q_we, bus.q_re, bus.out_valid, bus.out_data});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single();
        int ack_cyc[$];
        int out_cyc[$];
        logic [7:0] outs[$];
        logic [7:0] expd[3];
        do_reset();
        expd[0] = 8'h11; expd[1] = 8'h22; expd[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            pdata[0][k] = expd[k]; plast[0][k] = (k == 2);
        end
        plen[0] = 3;
        or_pct = 100; gap_pct = 0; qstall_pct = 0;
        drive();
        for (int c = 0; c < 20; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            if (bus.req_ack[0]) ack_cyc.push_back(m_cycle);
            if (bus.out_valid && bus.out_ready) begin
                outs.push_back(bus.out_data);
                out_cyc.push_back(m_cycle);
            end
            adv();
        end
        checks++;
        if (ack_cyc.size() != 3 || outs.size() != 3) begin
            errors++;
            $display("FAIL single.count acks=%0d outs=%0d exp=3/3", ack_cyc.size(), outs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outs[k] !== expd[k] || out_cyc[k] != out_cyc[0] + k || ack_cyc[k] != ack_cyc[0] + k) begin
                    errors++;
                    $display("FAIL single.order k=%0d got=%h exp=%h", k, outs[k], expd[k]);
                end
            end
            checks++;
            if (out_cyc[0] - ack_cyc[0] != SETTLE + 1) begin
                errors++;
                $display("FAIL single.latency got=%0d exp=%0d", out_cyc[0] - ack_cyc[0], SETTLE + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        int who[$];
        int when[$];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 6; k++) begin
                pdata[i][k] = 8'(16 * i + k); plast[i][k] = 1'b1;
            end
            plen[i] = 6;
        end
        drive();
        for (int c = 0; c < 14; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ack[i]) begin
                    who.push_back(i);
                    when.push_back(m_cycle);
                end
            end
            adv();
        end
        checks++;
        if (who.size() < 5) begin
            errors++;
            $display("FAIL rr.count got=%0d exp>=5", who.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (who[k] != k % NREQ || (k > 0 && when[k] - when[k-1] != 2)) begin
                    errors++;
                    $display("FAIL rr.order k=%0d got=%0d exp=%0d", k, who[k], k % NREQ);
                end
            end
        end
    endtask

    task automatic test_max_burst();
        int who[$];
        int expw[$];
        do_reset();
        for (int k = 0; k < 20; k++) begin
            pdata[2][k] = 8'(8'h80 + k); plast[2][k] = 1'b0;
        end
        plen[2] = 20;
        for (int k = 0; k < 3; k++) begin
            pdata[3][k] = 8'(8'hc0 + k); plast[3][k] = (k == 2);
        end
        plen[3] = 3;
        drive();
        for (int c = 0; c < 60; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) who.push_back(i);
            adv();
        end
        for (int k = 0; k < 16; k++) expw.push_back(2);
        for (int k = 0; k < 3; k++) expw.push_back(3);
        for (int k = 0; k < 4; k++) expw.push_back(2);
        checks++;
        if (who != expw) begin
            errors++;
            $display("FAIL burst.sequence got=%p exp=%p", who, expw);
        end
    endtask

    task automatic test_full();
        int acks;
        logic [7:0] outs[$];
        do_reset();
        for (int k = 0; k < 12; k++) begin
            pdata[0][k] = 8'(8'ha0 + k); plast[0][k] = (k == 11);
        end
        plen[0] = 12;
        or_pct = 0;
        drive();
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            if (bus.req_ack[0]) acks++;
            adv();
        end
        checks++;
        if (acks != 11 || bus.out_valid !== 1'b1 || bus.out_data !== 8'ha0) begin
            errors++;
            $display("FAIL full.stall acks=%0d ov=%b od=%h exp=11/1/a0", acks, bus.out_valid, bus.out_data);
        end
        or_pct = 100;
        drive();
        for (int c = 0; c < 40; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full.drain t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            if (bus.out_valid && bus.out_ready) outs.push_back(bus.out_data);
            adv();
        end
        checks++;
        if (outs.size() != 12) begin
            errors++;
            $display("FAIL full.delivered got=%0d exp=12", outs.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (outs[k] !== pdata[0][k]) begin
                    errors++;
                    $display("FAIL full.data k=%0d got=%h exp=%h", k, outs[k], pdata[0][k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int first;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            pdata[2][k] = 8'(8'h30 + k); plast[2][k] = 1'b0;
        end
        plen[2] = 10;
        drive();
        for (int c = 0; c < 4; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL arst.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            adv();
        end
        checks++;
        if (bus.q_we !== 1'b1) begin
            errors++;
            $display("FAIL arst.midburst q_we got=%b exp=1", bus.q_we);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ack, bus.q_we, bus.q_re, bus.out_valid, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL arst.outputs got=%h exp=0",
                     {bus.req_ack, bus.q_we, bus.q_re, bus.out_valid, bus.out_data});
        end
        #1 rst = 1'b1;
        clear_prod();
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            pdata[i][0] = 8'(8'h40 + i); plast[i][0] = 1'b0;
            pdata[i][1] = 8'(8'h50 + i); plast[i][1] = 1'b1;
            plen[i] = 2;
        end
        drive();
        first = -1;
        for (int c = 0; c < 10; c++) begin
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL arst.restart t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            for (int i = NREQ - 1; i >= 0; i--) if (first < 0 && bus.req_ack[i]) first = i;
            adv();
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL arst.first_grant got=%0d exp=0", first);
        end
    endtask

    task automatic test_random();
        int total, delivered, len;
        do_reset();
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            while (plen[i] < 40) begin
                len = int'($urandom_range(20, 1));
                for (int b = 0; b < len; b++) begin
                    pdata[i][plen[i]] = 8'($urandom);
                    plast[i][plen[i]] = (b == len - 1);
                    plen[i]++;
                end
            end
            total += plen[i];
        end
        gap_pct = 20; qstall_pct = 15; or_pct = 70;
        drive();
        delivered = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c == 800) begin
                gap_pct = 0; qstall_pct = 0; or_pct = 100;
            end
            half();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random.cycle t=%0d got=%h exp=%h", m_cycle, obs_vec(), exp_vec());
            end
            if (bus.out_valid && bus.out_ready) delivered++;
            adv();
        end
        checks++;
        if (delivered != total) begin
            errors++;
            $display("FAIL random.delivered got=%0d exp=%0d", delivered, total);
        end
    endtask

`ifdef DELAYQ_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pdata[0][k] = 8'(8'h60 + k); plast[0][k] = (k == 4);
        end
        plen[0] = 5;
        qstall_pct = 100;
        drive();
        for (int c = 0; c < 6; c++) begin
            half();
            adv();
        end
        half();
        checks++;
        if (stat_stall !== 16'd5) begin
            errors++;
            $display("FAIL stats.stall got=%0d exp=5", stat_stall);
        end
        qstall_pct = 0;
        adv();
        for (int c = 0; c < 30; c++) begin
            half();
            adv();
        end
        half();
        checks++;
        if (stat_bytes !== 16'd5 || stat_stall !== 16'd6) begin
            errors++;
            $display("FAIL stats.count bytes=%0d stall=%0d exp=5/6", stat_bytes, stat_stall);
        end
        adv();
        stat_clr = 1'b1;
        half();
        adv();
        stat_clr = 1'b0;
        half();
        checks++;
        if (stat_bytes !== 16'd0 || stat_stall !== 16'd0) begin
            errors++;
            $display("FAIL stats.clear bytes=%0d stall=%0d exp=0/0", stat_bytes, stat_stall);
        end
        adv();
    endtask
`endif

    initial begin
        rst        = 1'b0;
        bus.req    = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.q_oready = 1'b0;
        bus.out_ready = 1'b0;
        gap_pct = 0; qstall_pct = 0; or_pct = 100;
`ifdef DELAYQ_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        clear_prod();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_full();
        or_pct = 100;
        test_async_reset();
`ifdef DELAYQ_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
